// File: rtl/rifl_rst_pkg.sv
// -----------------------------------------------------------------------------
// rifl_rst_pkg
// Shared types and constants for the RIFL lane reset sequencer.
//   rifl_rst_state_t : sequencer state encoding
//   RIFL_RETRY_W     : width of the saturating timeout counter
//   rifl_max3        : elaboration-time helper used to size the cycle counter
// -----------------------------------------------------------------------------
package rifl_rst_pkg;

  typedef enum logic [2:0] {
    ST_RESET_GT  = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } rifl_rst_state_t;

  localparam int RIFL_RETRY_W = 8;

  function automatic int rifl_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/rifl_rst_seq.sv
// -----------------------------------------------------------------------------
// rifl_rst_seq
// Power-up / recovery reset sequencer for one RIFL lane (init clock domain).
// Holds the GT in reset, waits (with timeout) for PLL lock and TX/RX
// reset-done, waits a settle interval, then releases the frame reset. Loss of
// lock/ready in RUN, or a software request, restarts the sequence.
//
// Ports:
//   clk          in   init clock
//   rst_n        in   asynchronous active-low reset
//   sw_rst       in   software reset request (level, synchronous to clk)
//   gt_pll_lock  in   GT PLL lock (already synchronized to clk)
//   gt_tx_ready  in   GT TX reset-done (already synchronized to clk)
//   gt_rx_ready  in   GT RX reset-done (already synchronized to clk)
//   gt_rst       out  active-high GT reset request
//   rst          out  active-high frame-domain reset request
//   link_ready   out  high only in RUN
//   fail         out  sticky failure flag
//   retry_cnt    out  number of lock timeouts, saturating at 255
//
// Optional feature: define RIFL_RST_SEQ_RETRY_LIMIT_EN to park the sequencer
// in FAIL once more than MAX_RETRY timeouts have occurred. Without it the
// sequencer retries forever and fail is tied low.
// -----------------------------------------------------------------------------
module rifl_rst_seq
  import rifl_rst_pkg::*;
#(
  parameter int HOLD_CYCLES   = 128,
  parameter int LOCK_TIMEOUT  = 65536,
  parameter int SETTLE_CYCLES = 64,
  parameter int MAX_RETRY     = 7
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_rst,
  input  logic                    gt_pll_lock,
  input  logic                    gt_tx_ready,
  input  logic                    gt_rx_ready,
  output logic                    gt_rst,
  output logic                    rst,
  output logic                    link_ready,
  output logic                    fail,
  output logic [RIFL_RETRY_W-1:0] retry_cnt
);

  localparam int CNT_W = $clog2(rifl_max3(HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES)) + 1;

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [RIFL_RETRY_W-1:0] RETRY_LIMIT = RIFL_RETRY_W'(MAX_RETRY);

`ifdef RIFL_RST_SEQ_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  rifl_rst_state_t         state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [RIFL_RETRY_W-1:0] retry_q, retry_d, retry_inc;
  logic                    gt_rst_q, gt_rst_d;
  logic                    rst_q, rst_d;
  logic                    link_ready_q, link_ready_d;
  logic                    fail_q, fail_d;
  logic                    all_ok;

  assign all_ok = gt_pll_lock & gt_tx_ready & gt_rx_ready;

  // Saturating increment: retry_cnt sticks at 255 instead of wrapping.
  assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

  // NOTE: every signal assigned in this block gets a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;

    if (sw_rst) begin
      // Software request outranks everything except rst_n; holding it high
      // keeps the counter pinned at zero, extending the GT reset hold.
      state_d = ST_RESET_GT;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_RESET_GT: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end
        end
        ST_WAIT_LOCK: begin
          // Timeout outranks a simultaneous all_ok.
          if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_inc;
            state_d = (LIMIT_EN && (retry_q >= RETRY_LIMIT)) ? ST_FAIL : ST_RESET_GT;
            cnt_d   = '0;
          end else if (all_ok) begin
            state_d = ST_SETTLE;
            cnt_d   = '0;
          end
        end
        ST_SETTLE: begin
          // A drop restarts the lock wait with a fresh timeout window.
          if (!all_ok) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else if (cnt_q == SETTLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
        ST_RUN: begin
          cnt_d = cnt_q;
          if (!all_ok) begin
            state_d = ST_RESET_GT;
            cnt_d   = '0;
          end
        end
        ST_FAIL: begin
          cnt_d = cnt_q;
        end
        default: begin
          state_d = ST_RESET_GT;
          cnt_d   = '0;
        end
      endcase
    end

    // Outputs are decoded from the next state so they register on the same
    // edge as the state itself.
    gt_rst_d     = (state_d == ST_RESET_GT);
    rst_d        = (state_d != ST_RUN);
    link_ready_d = (state_d == ST_RUN);
`ifdef RIFL_RST_SEQ_RETRY_LIMIT_EN
    fail_d       = (state_d == ST_FAIL);
`else
    fail_d       = 1'b0;
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_RESET_GT;
      cnt_q        <= '0;
      retry_q      <= '0;
      gt_rst_q     <= 1'b1;
      rst_q        <= 1'b1;
      link_ready_q <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      gt_rst_q     <= gt_rst_d;
      rst_q        <= rst_d;
      link_ready_q <= link_ready_d;
      fail_q       <= fail_d;
    end
  end

  assign gt_rst     = gt_rst_q;
  assign rst        = rst_q;
  assign link_ready = link_ready_q;
  assign fail       = fail_q;
  assign retry_cnt  = retry_q;

endmodule

// File: tb/tb_rifl_rst_seq.sv
// -----------------------------------------------------------------------------
// tb_rifl_rst_seq
// Self-checking bench for rifl_rst_seq with HOLD=4, TIMEOUT=16, SETTLE=3,
// MAX_RETRY=2. A behavioural reference tracks which phase the sequence is in
// and how many edges it has spent there; directed steps cover power-up,
// timeouts, the retry limit, a settle glitch, loss in RUN and asynchronous
// reset, followed by randomized status/software-reset traffic.
// -----------------------------------------------------------------------------
module tb_rifl_rst_seq;

  localparam int HOLD   = 4;
  localparam int TMO    = 16;
  localparam int SETTLE = 3;
  localparam int MAXR   = 2;

`ifdef RIFL_RST_SEQ_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  // Reference phases
  localparam int P_HOLD = 0, P_LOCK = 1, P_SETTLE = 2, P_RUN = 3, P_FAIL = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sw_rst;
  logic       gt_pll_lock, gt_tx_ready, gt_rx_ready;
  logic       gt_rst, rst, link_ready, fail;
  logic [7:0] retry_cnt;

  int n_checks = 0;
  int n_errors = 0;

  int m_phase;
  int m_t;
  int m_retry;

  always #5 clk = ~clk;

  rifl_rst_seq #(
    .HOLD_CYCLES  (HOLD),
    .LOCK_TIMEOUT (TMO),
    .SETTLE_CYCLES(SETTLE),
    .MAX_RETRY    (MAXR)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_rst     (sw_rst),
    .gt_pll_lock(gt_pll_lock),
    .gt_tx_ready(gt_tx_ready),
    .gt_rx_ready(gt_rx_ready),
    .gt_rst     (gt_rst),
    .rst        (rst),
    .link_ready (link_ready),
    .fail       (fail),
    .retry_cnt  (retry_cnt)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_HOLD;
    m_t     = 0;
    m_retry = 0;
  endtask

  // One rising edge of the reference, using the inputs present at that edge.
  task automatic model_edge();
    bit ok;
    ok = gt_pll_lock && gt_tx_ready && gt_rx_ready;
    if (sw_rst) begin
      m_phase = P_HOLD;
      m_t     = 0;
      m_retry = 0;
    end else begin
      case (m_phase)
        P_HOLD: begin
          m_t++;
          if (m_t == HOLD) begin m_phase = P_LOCK; m_t = 0; end
        end
        P_LOCK: begin
          m_t++;
          if (m_t == TMO) begin
            m_phase = (LIMIT_EN && m_retry >= MAXR) ? P_FAIL : P_HOLD;
            m_retry = (m_retry < 255) ? m_retry + 1 : 255;
            m_t     = 0;
          end else if (ok) begin
            m_phase = P_SETTLE; m_t = 0;
          end
        end
        P_SETTLE: begin
          if (!ok) begin
            m_phase = P_LOCK; m_t = 0;
          end else begin
            m_t++;
            if (m_t == SETTLE) begin m_phase = P_RUN; m_t = 0; end
          end
        end
        P_RUN: if (!ok) begin m_phase = P_HOLD; m_t = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".gt_rst"},     8'(gt_rst),     8'(m_phase == P_HOLD));
    check({tag, ".rst"},        8'(rst),        8'(m_phase != P_RUN));
    check({tag, ".link_ready"}, 8'(link_ready), 8'(m_phase == P_RUN));
    check({tag, ".fail"},       8'(fail),       8'(m_phase == P_FAIL));
    check({tag, ".retry_cnt"},  retry_cnt,      8'(m_retry));
  endtask

  // Advance one clock, update the reference, then sample 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_outs(tag);
  endtask

  task automatic set_ok(input logic v);
    gt_pll_lock = v;
    gt_tx_ready = v;
    gt_rx_ready = v;
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_rst = 1'b0;
    set_ok(1'b0);
    model_reset();

    // Reset values
    #12;
    check_outs("reset");
    rst_n = 1'b1;

    // Power-up: gt_rst high for exactly HOLD edges; all_ok raised after 10
    for (int i = 1; i <= 10; i++) begin
      step("pwr");
      if (i == HOLD - 1) check("pwr_gt_rst_held", 8'(gt_rst), 8'd1);
      if (i == HOLD)     check("pwr_gt_rst_fall", 8'(gt_rst), 8'd0);
    end
    set_ok(1'b1);
    step("pwr_settle_enter");
    for (int i = 1; i <= SETTLE; i++) begin
      step("pwr_settle");
      if (i < SETTLE) check("pwr_rst_held", 8'(rst), 8'd1);
    end
    check("pwr_link_ready", 8'(link_ready), 8'd1);
    check("pwr_rst_release", 8'(rst), 8'd0);
    check("pwr_retry", retry_cnt, 8'd0);

    // Loss in RUN: drop RX ready, all outputs flip on the sampling edge
    gt_rx_ready = 1'b0;
    step("loss");
    check("loss_link_ready", 8'(link_ready), 8'd0);
    check("loss_rst", 8'(rst), 8'd1);
    check("loss_gt_rst", 8'(gt_rst), 8'd1);
    check("loss_retry", retry_cnt, 8'd0);

    // Recover; glitch all_ok for one cycle after two SETTLE cycles
    gt_rx_ready = 1'b1;
    repeat (HOLD + 1) step("glitch_pre");
    step("glitch_settle");
    gt_rx_ready = 1'b0;
    step("glitch_drop");
    check("glitch_rst", 8'(rst), 8'd1);
    gt_rx_ready = 1'b1;
    step("glitch_resettle");
    step("glitch_s1");
    step("glitch_s2");
    check("glitch_rst_held", 8'(rst), 8'd1);
    step("glitch_s3");
    check("glitch_run", 8'(link_ready), 8'd1);

    // Timeouts: gt_rst re-asserts every HOLD+TMO cycles, retry_cnt steps
    gt_pll_lock = 1'b0;
    step("tmo_drop");
    for (int k = 1; k <= 3; k++) begin
      repeat (HOLD) step("tmo_hold");
      check("tmo_gt_rst_low", 8'(gt_rst), 8'd0);
      repeat (TMO - 1) step("tmo_wait");
      check("tmo_no_early", 8'(gt_rst), 8'd0);
      step("tmo_fire");
      check("tmo_retry", retry_cnt, 8'(k));
      if (LIMIT_EN && k == 3) begin
        check("tmo_fail", 8'(fail), 8'd1);
        check("tmo_fail_gt_rst", 8'(gt_rst), 8'd0);
        check("tmo_fail_rst", 8'(rst), 8'd1);
      end else begin
        check("tmo_gt_rst_reassert", 8'(gt_rst), 8'd1);
      end
    end
    // FAIL (if enabled) must be sticky even when status recovers
    set_ok(1'b1);
    repeat (5) step("tmo_after");
    set_ok(1'b0);

    // Single-cycle software reset clears fail and retry_cnt
    sw_rst = 1'b1;
    step("sw");
    check("sw_fail", 8'(fail), 8'd0);
    check("sw_retry", retry_cnt, 8'd0);
    check("sw_gt_rst", 8'(gt_rst), 8'd1);
    sw_rst = 1'b0;

    // Asynchronous reset in the middle of WAIT_LOCK
    repeat (HOLD + 2) step("arst_pre");
    check("arst_in_wait", 8'(gt_rst), 8'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the reference
    for (int i = 0; i < 800; i++) begin
      gt_pll_lock = ($urandom_range(0, 99) < 90);
      gt_tx_ready = ($urandom_range(0, 99) < 92);
      gt_rx_ready = ($urandom_range(0, 99) < 92);
      if (i % 200 > 120) set_ok(1'b0);
      sw_rst = ($urandom_range(0, 127) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
